// File: rtl/tlk2711_tx_framer.sv
// ---------------------------------------------------------------------------
// tlk2711_tx_framer
//
// Transmit framer for the TLK2711 SERDES. It drives the 16-bit TXD bus and the
// device control pins from a single clock domain.
//
// Frame format: COMMA_CNT x COMMA, SOF, PAYLOAD_LEN payload words,
// optional CRC-16 word, EOF, then GAP_CNT idle commas before the next frame.
// Payload comes from an upstream valid/ready stream or from an internal
// counter pattern. Loopback, K-code idle and device-PRBS test modes are also
// provided. Stops are honoured only at frame boundaries and at the entry to
// IDLE a one-cycle acknowledge pulse is produced.
//
// Compile-time option:
//   TLK2711_TX_CRC_EN - when defined, a CRC-16-CCITT word (poly 0x1021,
//                       init 0xFFFF, MSB first, no reflection, no final XOR)
//                       over the frame's payload is sent between payload
//                       and EOF. When undefined no CRC logic exists.
//
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   i_start           - start request (rising edge, sampled in IDLE)
//   i_mode[2:0]       - 0 STREAM, 1 LOOP, 2 KCODE, 3 PRBS, 4 PATTERN
//   i_stop            - stop request (level)
//   o_stop_ack        - one-cycle pulse on re-entering IDLE after a stop
//   s_data/s_valid    - upstream payload stream
//   s_ready           - high in the data phase of STREAM mode
//   o_txd[15:0]       - TLK2711 TXD
//   o_tkmsb/o_tklsb   - K-character flags for TXD[15:8] / TXD[7:0]
//   o_loopen, o_prbsen, o_enable, o_lckrefn, o_testen - control pins
//   o_frame_cnt[31:0] - completed frames since reset (wraps)
//   o_busy            - high whenever the block is not in IDLE
// ---------------------------------------------------------------------------
module tlk2711_tx_framer #(
  parameter int PAYLOAD_LEN = 32,
  parameter int COMMA_CNT   = 2,
  parameter int GAP_CNT     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_mode,
  input  logic        i_stop,
  output logic        o_stop_ack,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] o_txd,
  output logic        o_tkmsb,
  output logic        o_tklsb,
  output logic        o_loopen,
  output logic        o_prbsen,
  output logic        o_enable,
  output logic        o_lckrefn,
  output logic        o_testen,
  output logic [31:0] o_frame_cnt,
  output logic        o_busy
);

  localparam logic [15:0] W_COMMA = 16'hC5BC;  // D5.6  | K28.5
  localparam logic [15:0] W_SOF   = 16'hABBC;  // D11.5 | K28.5
  localparam logic [15:0] W_EOF   = 16'h95BC;  // D21.4 | K28.5

  localparam logic [2:0] MODE_STREAM  = 3'd0;
  localparam logic [2:0] MODE_LOOP    = 3'd1;
  localparam logic [2:0] MODE_KCODE   = 3'd2;
  localparam logic [2:0] MODE_PRBS    = 3'd3;
  localparam logic [2:0] MODE_PATTERN = 3'd4;

  localparam int WC_W    = $clog2(PAYLOAD_LEN + 1);
  localparam int SEQ_MAX = (COMMA_CNT > GAP_CNT) ? COMMA_CNT : GAP_CNT;
  localparam int SEQ_W   = (SEQ_MAX < 2) ? 1 : $clog2(SEQ_MAX + 1);

  localparam logic [WC_W-1:0]  WC_LAST    = WC_W'(PAYLOAD_LEN - 1);
  localparam logic [SEQ_W-1:0] COMMA_LAST = SEQ_W'(COMMA_CNT - 1);
  localparam logic [SEQ_W-1:0] GAP_LAST   = SEQ_W'((GAP_CNT > 0) ? GAP_CNT - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE,
    S_KCODE,
    S_LOOP,
    S_PRBS,
    S_F_COMMA,
    S_F_SOF,
    S_F_DATA,
    S_F_CRC,
    S_F_EOF,
    S_F_GAP
  } state_t;

`ifdef TLK2711_TX_CRC_EN
  // One 16-bit word through CRC-16-CCITT, MSB first. Word width equals the
  // CRC width, so the whole word can be folded in before shifting.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                             input logic [15:0] data);
    logic [15:0] c;
    c = crc ^ data;
    for (int i = 0; i < 16; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction
`endif

  // Control state
  state_t            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic              start_prev_q;
  logic [SEQ_W-1:0]  scnt_q, scnt_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic              stop_q, stop_d;   // IDLE was entered because of a stop
`ifdef TLK2711_TX_CRC_EN
  logic [15:0]       crc_q, crc_d;
`endif

  // Registered pin outputs
  logic [15:0] txd_q, txd_d;
  logic        tklsb_q, tklsb_d;
  logic        loopen_q, loopen_d;
  logic        prbsen_q, prbsen_d;
  logic        enable_q, enable_d;
  logic        lckrefn_q, lckrefn_d;
  logic        stop_ack_q, stop_ack_d;

  logic start_rise;
  logic advance;

  assign start_rise = i_start & ~start_prev_q;
  assign s_ready    = (state_q == S_F_DATA) && (mode_q == MODE_STREAM);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    scnt_d      = scnt_q;
    wcnt_d      = wcnt_q;
    frame_cnt_d = frame_cnt_q;
    stop_d      = 1'b0;
`ifdef TLK2711_TX_CRC_EN
    crc_d       = crc_q;
`endif
    txd_d       = 16'h0000;
    tklsb_d     = 1'b0;
    loopen_d    = 1'b0;
    prbsen_d    = 1'b0;
    enable_d    = 1'b0;
    lckrefn_d   = 1'b1;
    stop_ack_d  = 1'b0;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // stop_q is only set on the cycle IDLE is first occupied, so the
        // acknowledge lines up with the first IDLE pin values.
        stop_ack_d = stop_q;
        if (start_rise) begin
          mode_d = i_mode;
          scnt_d = '0;
          case (i_mode)
            MODE_STREAM, MODE_PATTERN: state_d = S_F_COMMA;
            MODE_LOOP:                 state_d = S_LOOP;
            MODE_KCODE:                state_d = S_KCODE;
            MODE_PRBS:                 state_d = S_PRBS;
            default:                   state_d = S_IDLE;
          endcase
        end
      end

      S_KCODE, S_LOOP: begin
        enable_d = 1'b1;
        loopen_d = (state_q == S_LOOP);
        txd_d    = W_COMMA;
        tklsb_d  = 1'b1;
        if (i_stop) begin
          state_d = S_IDLE;
          stop_d  = 1'b1;
        end
      end

      S_PRBS: begin
        enable_d = 1'b1;
        prbsen_d = 1'b1;
        if (i_stop) begin
          state_d = S_IDLE;
          stop_d  = 1'b1;
        end
      end

      S_F_COMMA: begin
        enable_d = 1'b1;
        txd_d    = W_COMMA;
        tklsb_d  = 1'b1;
        if (scnt_q == COMMA_LAST) begin
          scnt_d  = '0;
          state_d = S_F_SOF;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end

      S_F_SOF: begin
        enable_d = 1'b1;
        txd_d    = W_SOF;
        tklsb_d  = 1'b1;
        wcnt_d   = '0;
`ifdef TLK2711_TX_CRC_EN
        crc_d    = 16'hFFFF;
`endif
        state_d  = S_F_DATA;
      end

      S_F_DATA: begin
        enable_d = 1'b1;
        if (mode_q == MODE_PATTERN) begin
          txd_d   = 16'(wcnt_q);
          advance = 1'b1;
        end else if (s_valid) begin
          txd_d   = s_data;
          advance = 1'b1;
        end else begin
          // Upstream starved: keep the link aligned with a fill comma.
          txd_d   = W_COMMA;
          tklsb_d = 1'b1;
        end
        if (advance) begin
`ifdef TLK2711_TX_CRC_EN
          crc_d = crc16_word(crc_q, txd_d);
`endif
          if (wcnt_q == WC_LAST) begin
`ifdef TLK2711_TX_CRC_EN
            state_d = S_F_CRC;
`else
            state_d = S_F_EOF;
`endif
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      S_F_CRC: begin
        enable_d = 1'b1;
`ifdef TLK2711_TX_CRC_EN
        txd_d    = crc_q;
`endif
        state_d  = S_F_EOF;
      end

      S_F_EOF: begin
        enable_d    = 1'b1;
        txd_d       = W_EOF;
        tklsb_d     = 1'b1;
        frame_cnt_d = frame_cnt_q + 32'd1;
        scnt_d      = '0;
        // The only point inside a frame where a stop request is honoured.
        if (i_stop) begin
          state_d = S_IDLE;
          stop_d  = 1'b1;
        end else if (GAP_CNT == 0) begin
          state_d = S_F_COMMA;
        end else begin
          state_d = S_F_GAP;
        end
      end

      S_F_GAP: begin
        enable_d = 1'b1;
        txd_d    = W_COMMA;
        tklsb_d  = 1'b1;
        if (scnt_q == GAP_LAST) begin
          scnt_d  = '0;
          state_d = S_F_COMMA;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_STREAM;
      start_prev_q <= 1'b0;
      scnt_q       <= '0;
      wcnt_q       <= '0;
      frame_cnt_q  <= 32'd0;
      stop_q       <= 1'b0;
`ifdef TLK2711_TX_CRC_EN
      crc_q        <= 16'h0000;
`endif
      txd_q        <= 16'h0000;
      tklsb_q      <= 1'b0;
      loopen_q     <= 1'b0;
      prbsen_q     <= 1'b0;
      enable_q     <= 1'b0;
      lckrefn_q    <= 1'b0;
      stop_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      start_prev_q <= i_start;
      scnt_q       <= scnt_d;
      wcnt_q       <= wcnt_d;
      frame_cnt_q  <= frame_cnt_d;
      stop_q       <= stop_d;
`ifdef TLK2711_TX_CRC_EN
      crc_q        <= crc_d;
`endif
      txd_q        <= txd_d;
      tklsb_q      <= tklsb_d;
      loopen_q     <= loopen_d;
      prbsen_q     <= prbsen_d;
      enable_q     <= enable_d;
      lckrefn_q    <= lckrefn_d;
      stop_ack_q   <= stop_ack_d;
    end
  end

  assign o_txd       = txd_q;
  assign o_tkmsb     = 1'b0;   // every K code used here sits in the low byte
  assign o_tklsb     = tklsb_q;
  assign o_loopen    = loopen_q;
  assign o_prbsen    = prbsen_q;
  assign o_enable    = enable_q;
  assign o_lckrefn   = lckrefn_q;
  assign o_testen    = 1'b0;
  assign o_stop_ack  = stop_ack_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule
